// File: rtl/decoder_seq_pkg.sv
// Shared types and constants for the queued one-hot decoder.
// Holds the FSM state enum and the code/output widths.
package decoder_seq_pkg;

   localparam int CODE_W = 4;
   localparam int OUT_W  = 16;

   typedef enum logic {
      IDLE,
      DRIVE
   } state_t;

   function automatic logic [OUT_W-1:0] onehot(
      input logic [CODE_W-1:0] code
   );
      return OUT_W'(1) << code;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter.
// The head entry is presented combinationally on dout.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Power-of-two depth lets the pointers wrap on overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/decoder_seq.sv
// Queued binary-to-one-hot decoder: codes wait in a FIFO and
// each is driven on decoder_out for HOLD cycles.
module decoder_seq
   import decoder_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int HOLD  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [CODE_W-1:0]        binary_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [OUT_W-1:0]         decoder_out,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CODE_W-1:0]  head;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign busy     = state == DRIVE;

   // cnt is zero whenever the FSM sits in IDLE.
   assign pop = enable && !empty && cnt == '0;

   sync_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (binary_in),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         decoder_out <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  state       <= DRIVE;
                  cnt         <= CNT_W'(HOLD-1);
                  decoder_out <= onehot(head);
               end else begin
                  decoder_out <= '0;
               end
            end
            DRIVE: begin
               if (!enable) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  decoder_out <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (pop) begin
                  cnt         <= CNT_W'(HOLD-1);
                  decoder_out <= onehot(head);
               end else begin
                  state       <= IDLE;
                  decoder_out <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: vector table plus
// hand-written abort, reset and full-FIFO sequences.
module tb_decoder_seq;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [3:0]  binary_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] decoder_out;
   logic        busy;
   logic [2:0]  fifo_count;

   int checks;
   int failures;

   typedef struct {
      logic        en;
      logic        v;
      logic [3:0]  code;
      logic        rdy;
      logic [15:0] dout;
      logic        busy;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   decoder_seq #(
      .DEPTH (4),
      .HOLD  (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .binary_in   (binary_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .decoder_out (decoder_out),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(
      input logic       en,
      input logic       v,
      input logic [3:0] code
   );
      enable    = en;
      in_valid  = v;
      binary_in = code;
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones(decoder_out) <= 1), 32'd1);
   endtask

   task automatic expect_out(
      input string       tag,
      input logic        rdy,
      input logic [15:0] dout,
      input logic        bsy,
      input logic [2:0]  cnt
   );
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      chk({tag, ".decoder_out"}, 32'(decoder_out), 32'(dout));
      chk({tag, ".busy"}, 32'(busy), 32'(bsy));
      chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(cnt));
   endtask

   task automatic add(
      input logic        en,
      input logic        v,
      input logic [3:0]  code,
      input logic        rdy,
      input logic [15:0] dout,
      input logic        bsy,
      input logic [2:0]  cnt
   );
      vec_t r;
      r.en   = en;
      r.v    = v;
      r.code = code;
      r.rdy  = rdy;
      r.dout = dout;
      r.busy = bsy;
      r.cnt  = cnt;
      vecs.push_back(r);
   endtask

   initial begin
      logic [15:0] exp_seq [12];
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      enable    = 1'b0;
      in_valid  = 1'b0;
      binary_in = '0;

      // Test 1: back-to-back 2, 6, 10, 14 with enable high.
      add(1, 1, 4'd2,  1, 16'h0000, 0, 3'd1);
      add(1, 1, 4'd6,  1, 16'h0004, 1, 3'd1);
      add(1, 1, 4'd10, 1, 16'h0004, 1, 3'd2);
      add(1, 1, 4'd14, 1, 16'h0004, 1, 3'd3);
      add(1, 0, 4'd0,  1, 16'h0040, 1, 3'd2);
      add(1, 0, 4'd0,  1, 16'h0040, 1, 3'd2);
      add(1, 0, 4'd0,  1, 16'h0040, 1, 3'd2);
      add(1, 0, 4'd0,  1, 16'h0400, 1, 3'd1);
      add(1, 0, 4'd0,  1, 16'h0400, 1, 3'd1);
      add(1, 0, 4'd0,  1, 16'h0400, 1, 3'd1);
      add(1, 0, 4'd0,  1, 16'h4000, 1, 3'd0);
      add(1, 0, 4'd0,  1, 16'h4000, 1, 3'd0);
      add(1, 0, 4'd0,  1, 16'h4000, 1, 3'd0);
      add(1, 0, 4'd0,  1, 16'h0000, 0, 3'd0);
      // Test 2: enable low, five pushes, fifth refused.
      add(0, 1, 4'd3,  1, 16'h0000, 0, 3'd1);
      add(0, 1, 4'd7,  1, 16'h0000, 0, 3'd2);
      add(0, 1, 4'd9,  1, 16'h0000, 0, 3'd3);
      add(0, 1, 4'd12, 0, 16'h0000, 0, 3'd4);
      add(0, 1, 4'd8,  0, 16'h0000, 0, 3'd4);
      // Test 3: drain over 12 cycles.
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 16'h0008, 1, 3'd3);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 16'h0080, 1, 3'd2);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 16'h0200, 1, 3'd1);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 16'h1000, 1, 3'd0);
      add(1, 0, 4'd0, 1, 16'h0000, 0, 3'd0);

      step(0, 0, 0);
      step(0, 0, 0);
      reset = 1'b0;
      expect_out("reset", 1, 16'h0000, 0, 3'd0);

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].v, vecs[i].code);
         expect_out($sformatf("vec%0d", i), vecs[i].rdy,
                    vecs[i].dout, vecs[i].busy, vecs[i].cnt);
      end

      // Test 4: abort code 15 on its 2nd hold cycle.
      step(0, 1, 4'd15);
      step(0, 1, 4'd1);
      step(1, 0, 0);
      expect_out("t4.hold1", 1, 16'h8000, 1, 3'd1);
      step(1, 0, 0);
      expect_out("t4.hold2", 1, 16'h8000, 1, 3'd1);
      step(0, 0, 0);
      expect_out("t4.abort", 1, 16'h0000, 0, 3'd1);
      step(0, 0, 0);
      expect_out("t4.wait", 1, 16'h0000, 0, 3'd1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0);
         expect_out($sformatf("t4.code1_%0d", i),
                    1, 16'h0002, 1, 3'd0);
      end
      step(1, 0, 0);
      expect_out("t4.idle", 1, 16'h0000, 0, 3'd0);

      // Test 5: reset mid-DRIVE with 3 codes queued.
      step(0, 1, 4'd4);
      step(0, 1, 4'd5);
      step(0, 1, 4'd6);
      step(0, 1, 4'd7);
      step(1, 0, 0);
      expect_out("t5.drive", 1, 16'h0010, 1, 3'd3);
      reset = 1'b1;
      step(1, 1, 4'd2);
      reset = 1'b0;
      expect_out("t5.reset", 1, 16'h0000, 0, 3'd0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0);
         expect_out($sformatf("t5.after%0d", i),
                    1, 16'h0000, 0, 3'd0);
      end

      // Test 6: full FIFO, pop and refused push same edge.
      step(0, 1, 4'd1);
      step(0, 1, 4'd2);
      step(0, 1, 4'd3);
      step(0, 1, 4'd4);
      expect_out("t6.full", 0, 16'h0000, 0, 3'd4);
      step(1, 1, 4'd9);
      expect_out("t6.poppush", 1, 16'h0002, 1, 3'd3);
      for (int i = 0; i < 12; i++) begin
         exp_seq[i] = 16'h0002 << (i / 3);
      end
      for (int i = 1; i < 12; i++) begin
         step(1, 0, 0);
         chk($sformatf("t6.drain%0d", i),
             32'(decoder_out), 32'(exp_seq[i]));
      end
      step(1, 0, 0);
      expect_out("t6.end", 1, 16'h0000, 0, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
